// File: rtl/rds_group_decoder.sv
// rtl/rds_group_decoder.sv - RDS block sync, group assembly, PI/group type report and PS name writes
module rds_group_decoder #(
  parameter int SYNC_LOSS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        synced,
  output logic [15:0] pi_code,
  output logic [4:0]  group_type,
  output logic        group_valid,
  output logic        ps_we,
  output logic [2:0]  ps_addr,
  output logic [7:0]  ps_data
);

  localparam logic [9:0] OFF_A  = 10'h0FC;
  localparam logic [9:0] OFF_B  = 10'h198;
  localparam logic [9:0] OFF_C  = 10'h168;
  localparam logic [9:0] OFF_CP = 10'h350;
  localparam logic [9:0] OFF_D  = 10'h1B4;

  typedef enum logic {SEARCH, SYNCED} state_t;

  state_t      state, state_next;
  logic [25:0] win;
  logic        eval_q;
  logic [4:0]  bit_cnt;
  logic [1:0]  blk_idx;
  logic [3:0]  bad_cnt;
  logic [3:0]  good_mask;
  logic [15:0] slot_a;
  logic [4:0]  slot_type;
  logic [1:0]  slot_seg;
  logic [15:0] wr_word;
  logic [1:0]  wr_seg;
  logic [1:0]  wr_phase;

  logic [9:0]  syn;
  logic        m_a, m_b, m_c, m_cp, m_d, any_match, exp_match;
  logic        blk_end, blk_good, blk_bad, lose, acquire, group_done;

  function automatic logic [9:0] crc10(input logic [15:0] info);
    logic [9:0] r;
    logic       fb;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      fb = r[9] ^ info[i];
      r  = {r[8:0], 1'b0};
      if (fb) r = r ^ 10'h1B9;
    end
    return r;
  endfunction

  always_comb begin
    syn       = crc10(win[25:10]);
    m_a       = ((syn ^ OFF_A)  == win[9:0]);
    m_b       = ((syn ^ OFF_B)  == win[9:0]);
    m_c       = ((syn ^ OFF_C)  == win[9:0]);
    m_cp      = ((syn ^ OFF_CP) == win[9:0]);
    m_d       = ((syn ^ OFF_D)  == win[9:0]);
    any_match = m_a | m_b | m_c | m_cp | m_d;
    exp_match = 1'b0;
    case (blk_idx)
      2'd0:    exp_match = m_a;
      2'd1:    exp_match = m_b;
      2'd2:    exp_match = m_c | m_cp;
      default: exp_match = m_d;
    endcase
    blk_end    = eval_q && (state == SYNCED) && (bit_cnt == 5'd25);
    blk_good   = blk_end && exp_match;
    blk_bad    = blk_end && !exp_match;
    lose       = blk_bad && (({1'b0, bad_cnt} + 5'd1) >= 5'(SYNC_LOSS));
    acquire    = eval_q && (state == SEARCH) && any_match;
    group_done = blk_good && (blk_idx == 2'd3) && (good_mask[2:0] == 3'b111);
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (acquire) state_next = SYNCED;
      SYNCED:  if (lose)    state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= state_next;
  end

  assign synced = (state == SYNCED);

  // Block tracking: acquisition seeds the block index from whichever offset matched.
  always_ff @(posedge clk) begin
    if (rst) begin
      win       <= '0;
      eval_q    <= 1'b0;
      bit_cnt   <= '0;
      blk_idx   <= '0;
      bad_cnt   <= '0;
      good_mask <= '0;
      slot_a    <= '0;
      slot_type <= '0;
      slot_seg  <= '0;
    end else begin
      eval_q <= bit_valid;
      if (bit_valid) win <= {win[24:0], bit_in};
      if (acquire) begin
        bit_cnt   <= '0;
        bad_cnt   <= '0;
        blk_idx   <= m_a ? 2'd1 : m_b ? 2'd2 : (m_c | m_cp) ? 2'd3 : 2'd0;
        good_mask <= m_a ? 4'b0001 : 4'b0000;
        if (m_a) slot_a <= win[25:10];
      end else if (eval_q && (state == SYNCED)) begin
        if (bit_cnt == 5'd25) begin
          bit_cnt <= '0;
          blk_idx <= blk_idx + 2'd1;
          if (exp_match) begin
            bad_cnt   <= '0;
            good_mask <= (blk_idx == 2'd0) ? 4'b0001 : (good_mask | (4'b0001 << blk_idx));
            if (blk_idx == 2'd0) slot_a <= win[25:10];
            if (blk_idx == 2'd1) begin
              slot_type <= win[25:21];
              slot_seg  <= win[11:10];
            end
          end else begin
            bad_cnt   <= lose ? 4'd0 : bad_cnt + 4'd1;
            good_mask <= (lose || blk_idx == 2'd0) ? 4'b0000 : (good_mask & ~(4'b0001 << blk_idx));
          end
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

  // Group report and the two-beat PS character write that follows a type-0 group.
  always_ff @(posedge clk) begin
    if (rst) begin
      group_valid <= 1'b0;
      pi_code     <= '0;
      group_type  <= '0;
      wr_word     <= '0;
      wr_seg      <= '0;
      wr_phase    <= '0;
      ps_we       <= 1'b0;
      ps_addr     <= '0;
      ps_data     <= '0;
    end else begin
      group_valid <= group_done;
      if (group_done) begin
        pi_code    <= slot_a;
        group_type <= slot_type;
        wr_word    <= win[25:10];
        wr_seg     <= slot_seg;
        wr_phase   <= (slot_type[4:1] == 4'd0) ? 2'd1 : 2'd0;
      end
      case (wr_phase)
        2'd1: begin
          ps_we    <= 1'b1;
          ps_addr  <= {wr_seg, 1'b0};
          ps_data  <= wr_word[15:8];
          wr_phase <= 2'd2;
        end
        2'd2: begin
          ps_we    <= 1'b1;
          ps_addr  <= {wr_seg, 1'b1};
          ps_data  <= wr_word[7:0];
          wr_phase <= 2'd0;
        end
        default: ps_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rds_group_decoder.sv
// tb/tb_rds_group_decoder.sv - scoreboard bench for rds_group_decoder
module tb_rds_group_decoder;

  localparam logic [9:0] OFF_A  = 10'h0FC;
  localparam logic [9:0] OFF_B  = 10'h198;
  localparam logic [9:0] OFF_C  = 10'h168;
  localparam logic [9:0] OFF_CP = 10'h350;
  localparam logic [9:0] OFF_D  = 10'h1B4;
  // Parity contribution of info bit i (bit 0 = last transmitted info bit).
  localparam logic [9:0] H_ROWS [16] = '{10'h1B9, 10'h372, 10'h35D, 10'h303, 10'h3BF, 10'h2C7,
                                        10'h037, 10'h06E, 10'h0DC, 10'h1B8, 10'h370, 10'h359,
                                        10'h30B, 10'h3AF, 10'h2E7, 10'h077};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        synced;
  logic [15:0] pi_code;
  logic [4:0]  group_type;
  logic        group_valid;
  logic        ps_we;
  logic [2:0]  ps_addr;
  logic [7:0]  ps_data;

  rds_group_decoder #(.SYNC_LOSS(3)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .synced(synced), .pi_code(pi_code), .group_type(group_type),
    .group_valid(group_valid), .ps_we(ps_we), .ps_addr(ps_addr), .ps_data(ps_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pi; logic [4:0] gt; } grp_t;
  typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;

  grp_t gq[$];
  wr_t  pq[$];
  logic stream[$];
  int   checks = 0;
  int   errors = 0;
  int   since_gv = 99;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] crc_ref(input logic [15:0] info);
    logic [9:0] r = '0;
    for (int i = 0; i < 16; i++) if (info[i]) r ^= H_ROWS[i];
    return r;
  endfunction

  function automatic logic [25:0] mk_block(input logic [15:0] info, input logic [9:0] off);
    return {info, crc_ref(info) ^ off};
  endfunction

  function automatic bit hit(input logic [25:0] w, input logic [9:0] off);
    return (crc_ref(w[25:10]) ^ off) == w[9:0];
  endfunction

  function automatic bit any_hit(input logic [25:0] w);
    return hit(w, OFF_A) || hit(w, OFF_B) || hit(w, OFF_C) || hit(w, OFF_CP) || hit(w, OFF_D);
  endfunction

  function automatic bit spurious(input int lo, input int hi);
    logic [25:0] w;
    for (int k = lo; k <= hi; k++) begin
      w = '0;
      for (int j = k - 25; j <= k; j++) if (j >= 0) w = {w[24:0], stream[j]};
      if (any_hit(w)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push_word(input logic [25:0] w);
    for (int i = 25; i >= 0; i--) stream.push_back(w[i]);
  endtask

  task automatic add_group(input logic [15:0] pi, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] d, input bit with_a, input bit flip_c);
    logic [25:0] cw;
    cw = mk_block(c, b[11] ? OFF_CP : OFF_C);
    if (flip_c) cw[20] = ~cw[20];
    if (with_a) push_word(mk_block(pi, OFF_A));
    push_word(mk_block(b, OFF_B));
    push_word(cw);
    push_word(mk_block(d, OFF_D));
  endtask

  task automatic expect_group(input logic [15:0] pi, input logic [15:0] b, input logic [15:0] d);
    gq.push_back('{pi, b[15:11]});
    if (b[15:12] == 4'd0) begin
      pq.push_back('{{b[1:0], 1'b0}, d[15:8]});
      pq.push_back('{{b[1:0], 1'b1}, d[7:0]});
    end
  endtask

  task automatic drive_bit(input logic b, input bit do_chk, input logic pre, input logic post);
    @(negedge clk);
    bit_in = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    if (do_chk) chk("synced_before", 32'(synced), 32'(pre));
    @(negedge clk);
    if (do_chk) chk("synced_after", 32'(synced), 32'(post));
    repeat (5) @(negedge clk);
  endtask

  task automatic send(input int lo, input int hi, input int ci, input logic pre, input logic post);
    for (int i = lo; i <= hi; i++) drive_bit(stream[i], i == ci, pre, post);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bit_valid = 1'b0;
    stream.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
    chk("groups_left", 32'(gq.size()), 0);
    chk("writes_left", 32'(pq.size()), 0);
    gq.delete();
    pq.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_synced"}, 32'(synced), 0);
    chk({tag, "_pi"}, 32'(pi_code), 0);
    chk({tag, "_gtype"}, 32'(group_type), 0);
    chk({tag, "_gv"}, 32'(group_valid), 0);
    chk({tag, "_we"}, 32'(ps_we), 0);
    chk({tag, "_addr"}, 32'(ps_addr), 0);
    chk({tag, "_data"}, 32'(ps_data), 0);
  endtask

  always @(negedge clk) begin : monitor
    grp_t g;
    wr_t  w;
    if (group_valid) begin
      since_gv = 0;
      if (gq.size() == 0) chk("group_unexpected", 32'(group_valid), 0);
      else begin
        g = gq.pop_front();
        chk("pi_code", 32'(pi_code), 32'(g.pi));
        chk("group_type", 32'(group_type), 32'(g.gt));
      end
    end else if (since_gv < 99) since_gv++;
    if (ps_we) begin
      if (pq.size() == 0) chk("ps_unexpected", 32'(ps_we), 0);
      else begin
        w = pq.pop_front();
        chk("ps_addr", 32'(ps_addr), 32'(w.a));
        chk("ps_data", 32'(ps_data), 32'(w.d));
        chk("ps_delay", 32'(since_gv), w.a[0] ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin : timeout
    #3_000_000;
    $display("FAIL timeout: bench did not finish, checks %0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int   tries;
    logic [25:0] b1, b2, b3;
    logic found;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Aligned 0A group straight after reset.
    add_group(16'h1234, 16'h0002, 16'h4142, 16'h464D, 1'b1, 1'b0);
    expect_group(16'h1234, 16'h0002, 16'h464D);
    send(0, stream.size() - 1, 25, 1'b0, 1'b1);
    drain();
    chk("hold_pi", 32'(pi_code), 32'h1234);
    chk("hold_gtype", 32'(group_type), 0);

    // 7 noise bits, then three groups starting at block A.
    do_reset();
    found = 1'b0;
    for (tries = 0; tries < 200 && !found; tries++) begin
      stream.delete();
      repeat (7) stream.push_back(1'($urandom()));
      add_group(16'hC0DE, 16'h0000, 16'h1111, 16'h4142, 1'b1, 1'b0);
      add_group(16'hC0DE, 16'h0001, 16'h2222, 16'h4344, 1'b1, 1'b0);
      add_group(16'hC0DE, 16'h0003, 16'h3333, 16'h4546, 1'b1, 1'b0);
      found = !spurious(0, 31);
    end
    chk("noise_gen_a", 32'(found), 1);
    expect_group(16'hC0DE, 16'h0000, 16'h4142);
    expect_group(16'hC0DE, 16'h0001, 16'h4344);
    expect_group(16'hC0DE, 16'h0003, 16'h4546);
    send(0, stream.size() - 1, 32, 1'b0, 1'b1);
    drain();

    // Same shape but the first group is cut to B,C,D: that partial group must stay silent.
    do_reset();
    found = 1'b0;
    for (tries = 0; tries < 200 && !found; tries++) begin
      stream.delete();
      repeat (7) stream.push_back(1'($urandom()));
      add_group(16'hBEEF, 16'h0000, 16'h1111, 16'h5859, 1'b0, 1'b0);
      add_group(16'hBEEF, 16'h0801, 16'hBEEF, 16'h5A5B, 1'b1, 1'b0);
      add_group(16'hBEEF, 16'h0002, 16'h3333, 16'h5C5D, 1'b1, 1'b0);
      found = !spurious(0, 31);
    end
    chk("noise_gen_b", 32'(found), 1);
    expect_group(16'hBEEF, 16'h0801, 16'h5A5B);
    expect_group(16'hBEEF, 16'h0002, 16'h5C5D);
    send(0, stream.size() - 1, 32, 1'b0, 1'b1);
    drain();

    // One flipped bit in block C of the middle group.
    do_reset();
    add_group(16'h1234, 16'h0000, 16'h0101, 16'h3132, 1'b1, 1'b0);
    add_group(16'h1234, 16'h0001, 16'h0202, 16'h3334, 1'b1, 1'b1);
    add_group(16'h1234, 16'h0002, 16'h0303, 16'h3536, 1'b1, 1'b0);
    expect_group(16'h1234, 16'h0000, 16'h3132);
    expect_group(16'h1234, 16'h0002, 16'h3536);
    send(0, stream.size() - 1, 25, 1'b0, 1'b1);
    drain();
    chk("flip_synced", 32'(synced), 1);

    // Three consecutive bad blocks drop sync; a clean stream re-acquires.
    do_reset();
    found = 1'b0;
    for (tries = 0; tries < 500 && !found; tries++) begin
      stream.delete();
      add_group(16'h1234, 16'h0003, 16'h0404, 16'h6162, 1'b1, 1'b0);
      b1 = 26'($urandom());
      b2 = 26'($urandom());
      b3 = 26'($urandom());
      push_word(b1);
      push_word(b2);
      push_word(b3);
      add_group(16'h7777, 16'h0000, 16'h0505, 16'h6364, 1'b1, 1'b0);
      add_group(16'h7777, 16'h0001, 16'h0606, 16'h6566, 1'b1, 1'b0);
      add_group(16'h7777, 16'h0002, 16'h0707, 16'h6768, 1'b1, 1'b0);
      found = !hit(b1, OFF_A) && !hit(b2, OFF_B) && !hit(b3, OFF_C) && !hit(b3, OFF_CP)
              && !spurious(182, 206);
    end
    chk("loss_gen", 32'(found), 1);
    expect_group(16'h1234, 16'h0003, 16'h6162);
    expect_group(16'h7777, 16'h0000, 16'h6364);
    expect_group(16'h7777, 16'h0001, 16'h6566);
    expect_group(16'h7777, 16'h0002, 16'h6768);
    send(0, stream.size() - 1, 181, 1'b1, 1'b0);
    drain();
    chk("reacq_synced", 32'(synced), 1);

    // Group 2A decodes but writes nothing.
    do_reset();
    add_group(16'h1234, 16'h2000, 16'h4865, 16'h6C6C, 1'b1, 1'b0);
    expect_group(16'h1234, 16'h2000, 16'h6C6C);
    send(0, stream.size() - 1, 25, 1'b0, 1'b1);
    drain();
    chk("type2a_gtype", 32'(group_type), 32'h04);

    // Reset landing on the first PS write cancels the second one.
    do_reset();
    add_group(16'h1234, 16'h0001, 16'h0909, 16'h5241, 1'b1, 1'b0);
    gq.push_back('{16'h1234, 5'd0});
    pq.push_back('{3'd2, 8'h52});
    send(0, stream.size() - 2, -1, 1'b0, 1'b0);
    @(negedge clk);
    bit_in = stream[stream.size() - 1];
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    for (int i = 0; i < 8 && !ps_we; i++) @(negedge clk);
    chk("abort_first_we", 32'(ps_we), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_second_we", 32'(ps_we), 0);
    chk("abort_unsynced", 32'(synced), 0);
    stream.delete();
    add_group(16'h1234, 16'h0003, 16'h0A0A, 16'h2020, 1'b1, 1'b0);
    expect_group(16'h1234, 16'h0003, 16'h2020);
    send(0, stream.size() - 1, 25, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
